// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit path.
//   i2s_state_e          : serializer frame state (idle, left slot, right slot)
//   SAMPLE_WIDTH_DEFAULT : default bits per channel sample
//   UNDERRUN_CNT_W       : width of the saturating underrun counter
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2s_state_e;

  localparam int SAMPLE_WIDTH_DEFAULT = 24;
  localparam int UNDERRUN_CNT_W       = 8;

endpackage

// File: rtl/i2s_clock_edge_detect.sv
// Detects bit-clock falling edges and word-clock transitions in the system
// clock domain. bclk and wclk arrive as registered levels from the clock unit.
// A wclk change is only recognised on a bclk falling edge, so a change that
// lands on a bclk rising edge shows up at the following fall.
// Ports:
//   synthClk   : system clock
//   synthReset : asynchronous active-high reset
//   restart    : synchronous resync, clears edge history
//   bclk, wclk : bit / word clock levels
//   bclkFall   : high in the cycle bclk is first seen low after high
//   toggle     : high on a bclkFall cycle where wclk differs from its last value
module i2s_clock_edge_detect (
  input  logic synthClk,
  input  logic synthReset,
  input  logic restart,
  input  logic bclk,
  input  logic wclk,
  output logic bclkFall,
  output logic toggle
);

  logic bclkPrev_q;
  logic wclkLast_q;

  always_ff @(posedge synthClk or posedge synthReset) begin
    if (synthReset) begin
      bclkPrev_q <= 1'b0;
      wclkLast_q <= 1'b0;
    end else if (restart) begin
      bclkPrev_q <= 1'b0;
      wclkLast_q <= 1'b0;
    end else begin
      bclkPrev_q <= bclk;
      if (bclkFall) wclkLast_q <= wclk;
    end
  end

  assign bclkFall = bclkPrev_q & ~bclk;
  assign toggle   = bclkFall & (wclk ^ wclkLast_q);

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer. Buffers one stereo pair from a valid/ready source
// and shifts it MSB-first onto sd, one bit per bclk falling edge, with the
// standard one-bit delay after each wclk transition (left slot while wclk=0).
// Ports:
//   synthClk, synthReset     : system clock, asynchronous active-high reset
//   bclk, wclk               : bit / word clock levels from the clock unit
//   restart                  : synchronous resync (clock unit load)
//   txEnable                 : transmit enable, acted on at frame boundaries
//   sampleValid/sampleReady  : upstream handshake for one stereo pair
//   sampleLeft, sampleRight  : pair data
//   sd                       : registered serial data
//   underrun                 : one-cycle pulse, frame began with no pair buffered
//   underrunCount            : saturating underrun count
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT
) (
  input  logic                      synthClk,
  input  logic                      synthReset,
  input  logic                      bclk,
  input  logic                      wclk,
  input  logic                      restart,
  input  logic                      txEnable,
  input  logic                      sampleValid,
  input  logic [SAMPLE_WIDTH-1:0]   sampleLeft,
  input  logic [SAMPLE_WIDTH-1:0]   sampleRight,
  output logic                      sampleReady,
  output logic                      sd,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrunCount
);

  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(
    input logic [UNDERRUN_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  logic bclkFall;
  logic toggle;

  i2s_clock_edge_detect u_edge (
    .synthClk  (synthClk),
    .synthReset(synthReset),
    .restart   (restart),
    .bclk      (bclk),
    .wclk      (wclk),
    .bclkFall  (bclkFall),
    .toggle    (toggle)
  );

  i2s_state_e                state_q, state_d;
  logic [SAMPLE_WIDTH-1:0]   shreg_q;
  logic [SAMPLE_WIDTH-1:0]   rightWord_q;
  logic [SAMPLE_WIDTH-1:0]   holdL_q;
  logic [SAMPLE_WIDTH-1:0]   holdR_q;
  logic                      holdValid_q;
  logic                      sd_q;
  logic                      underrun_q;
  logic [UNDERRUN_CNT_W-1:0] underrunCount_q;
  logic [SAMPLE_WIDTH-1:0]   newWord_d;
  logic                      frameStart;
  logic                      accept;

  assign sampleReady   = ~holdValid_q;
  assign accept        = sampleValid & ~holdValid_q;
  assign sd            = sd_q;
  assign underrun      = underrun_q;
  assign underrunCount = underrunCount_q;

  // Slot decode: decides the next state and the word loaded on a wclk toggle.
  always_comb begin
    state_d    = state_q;
    frameStart = 1'b0;
    newWord_d  = '0;
    if (toggle) begin
      case (state_q)
        // A toggle to wclk=1 while idle is ignored so frames always open on a left slot.
        ST_IDLE: begin
          if (txEnable && !wclk) begin
            frameStart = 1'b1;
            state_d    = ST_LEFT;
          end
        end
        ST_LEFT: begin
          newWord_d = rightWord_q;
          state_d   = ST_RIGHT;
        end
        ST_RIGHT: begin
          if (txEnable) begin
            frameStart = 1'b1;
            state_d    = ST_LEFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (frameStart && holdValid_q) newWord_d = holdL_q;
    end
  end

  // Serializer, holding-buffer control and frame FSM.
  always_ff @(posedge synthClk or posedge synthReset) begin
    if (synthReset) begin
      state_q         <= ST_IDLE;
      shreg_q         <= '0;
      rightWord_q     <= '0;
      sd_q            <= 1'b0;
      underrun_q      <= 1'b0;
      underrunCount_q <= '0;
      holdValid_q     <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      // Accept needs an empty buffer and consume needs a full one, so the
      // two writes to holdValid_q below never fire together.
      if (accept) holdValid_q <= 1'b1;
      if (restart) begin
        state_q         <= ST_IDLE;
        shreg_q         <= '0;
        sd_q            <= 1'b0;
        underrunCount_q <= '0;
      end else if (bclkFall) begin
        // The toggle edge still emits the old slot's last bit: the I2S one-bit delay.
        sd_q    <= shreg_q[SAMPLE_WIDTH-1];
        shreg_q <= toggle ? newWord_d : (shreg_q << 1);
        state_q <= state_d;
        if (frameStart) begin
          if (holdValid_q) begin
            rightWord_q <= holdR_q;
            holdValid_q <= 1'b0;
          end else begin
            rightWord_q     <= '0;
            underrun_q      <= 1'b1;
            underrunCount_q <= sat_inc(underrunCount_q);
          end
        end
      end
    end
  end

  // Hold data is only meaningful while holdValid_q is set, so it needs no reset.
  always_ff @(posedge synthClk) begin
    if (accept) begin
      holdL_q <= sampleLeft;
      holdR_q <= sampleRight;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: a clock-unit model produces bclk (half-period
// 4 synthClk) and wclk (changes on bclk falls, slotBits bits per slot), and an
// I2S receiver model collects {channel, word} at every wclk change.
module tb_i2s_tx_serializer;

  logic        synthClk = 1'b0;
  logic        synthReset = 1'b1;
  logic        bclk = 1'b0;
  logic        wclk = 1'b0;
  logic        restart = 1'b0;
  logic        txEnable = 1'b0;
  logic        sampleValid = 1'b0;
  logic [23:0] sampleLeft = '0;
  logic [23:0] sampleRight = '0;
  logic        sampleReady;
  logic        sd;
  logic        underrun;
  logic [7:0]  underrunCount;

  int tests = 0;
  int fails = 0;

  int          hc = 0;
  int          bc = 0;
  int          slotBits = 32;
  bit          ckrun = 1'b0;
  bit          cuLoad = 1'b0;
  bit          rxW = 1'b0;
  logic [63:0] rxsh = '0;
  logic [32:0] rxq[$];
  int          urCnt = 0;

  i2s_tx_serializer #(.SAMPLE_WIDTH(24)) dut (
    .synthClk     (synthClk),
    .synthReset   (synthReset),
    .bclk         (bclk),
    .wclk         (wclk),
    .restart      (restart),
    .txEnable     (txEnable),
    .sampleValid  (sampleValid),
    .sampleLeft   (sampleLeft),
    .sampleRight  (sampleRight),
    .sampleReady  (sampleReady),
    .sd           (sd),
    .underrun     (underrun),
    .underrunCount(underrunCount)
  );

  initial forever #5 synthClk = ~synthClk;

  function automatic logic [31:0] wmask(input int n);
    logic [32:0] m;
    m = (33'd1 << n) - 33'd1;
    return m[31:0];
  endfunction

  function automatic logic [32:0] getq(input int i);
    if (i < rxq.size()) return rxq[i];
    return 33'h1DEADBEEF;
  endfunction

  // Clock unit and I2S receiver, updated on falling synthClk edges.
  initial forever begin
    @(negedge synthClk);
    if (underrun === 1'b1) urCnt++;
    if (cuLoad) begin
      hc = 0; bc = 0; bclk = 1'b0; wclk = 1'b0;
      rxW = 1'b0; rxsh = '0; rxq.delete(); urCnt = 0;
    end else if (ckrun) begin
      hc++;
      if (hc == 4) begin
        hc = 0;
        if (bclk) begin
          bclk = 1'b0;
          bc++;
          if (bc == slotBits) begin
            bc = 0;
            wclk = ~wclk;
          end
        end else begin
          bclk = 1'b1;
          rxsh = {rxsh[62:0], sd};
          if (wclk != rxW) rxq.push_back({rxW, rxsh[31:0] & wmask(slotBits)});
          rxW = wclk;
        end
      end
    end
  end

  task automatic resync(input int slot);
    @(negedge synthClk);
    slotBits = slot; cuLoad = 1'b1; restart = 1'b1; ckrun = 1'b1;
    @(negedge synthClk);
    @(negedge synthClk);
    cuLoad = 1'b0; restart = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int t = 0;
    while (rxq.size() < n && t < 30000) begin
      @(negedge synthClk); #1; t++;
    end
    if (rxq.size() < n) begin
      tests++; fails++;
      $display("FAIL wait_q: got %0d words required %0d", rxq.size(), n);
    end
  endtask

  task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
    int t = 0;
    sampleLeft = l; sampleRight = r; sampleValid = 1'b1;
    while (!sampleReady && t < 6000) begin
      @(negedge synthClk); t++;
    end
    @(negedge synthClk);
    sampleValid = 1'b0;
    if (t >= 6000) begin
      tests++; fails++;
      $display("FAIL send_pair: sampleReady never rose, required 1");
    end
  endtask

  task automatic test_reset;
    synthReset = 1'b1;
    repeat (3) @(negedge synthClk);
    tests++; if (sampleReady !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", sampleReady); end
    tests++; if (sd !== 1'b0) begin fails++; $display("FAIL reset_sd: got %b required 0", sd); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b required 0", underrun); end
    tests++; if (underrunCount !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d required 0", underrunCount); end
    synthReset = 1'b0;
    @(negedge synthClk);
    tests++; if (sampleReady !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b required 1", sampleReady); end
  endtask

  task automatic test_basic;
    resync(32);
    txEnable = 1'b1;
    send_pair(24'hA5A5A5, 24'h3C3C3C);
    tests++; if (sampleReady !== 1'b0) begin fails++; $display("FAIL basic_ready_drop: got %b required 0", sampleReady); end
    wait_q(1);
    tests++; if (sampleReady !== 1'b0) begin fails++; $display("FAIL basic_ready_held: got %b required 0", sampleReady); end
    wait_q(3);
    tests++; if (sampleReady !== 1'b1) begin fails++; $display("FAIL basic_ready_back: got %b required 1", sampleReady); end
    tests++; if (urCnt !== 0) begin fails++; $display("FAIL basic_no_underrun: got %0d required 0", urCnt); end
    wait_q(4);
    tests++; if (getq(0) !== {1'b0, 32'h0}) begin fails++; $display("FAIL basic_idle0: got %h required %h", getq(0), {1'b0, 32'h0}); end
    tests++; if (getq(1) !== {1'b1, 32'h0}) begin fails++; $display("FAIL basic_idle1: got %h required %h", getq(1), {1'b1, 32'h0}); end
    tests++; if (getq(2) !== {1'b0, 32'hA5A5A500}) begin fails++; $display("FAIL basic_left: got %h required %h", getq(2), {1'b0, 32'hA5A5A500}); end
    tests++; if (getq(3) !== {1'b1, 32'h3C3C3C00}) begin fails++; $display("FAIL basic_right: got %h required %h", getq(3), {1'b1, 32'h3C3C3C00}); end
  endtask

  task automatic test_back_to_back;
    logic [23:0] bl[4] = '{24'h123456, 24'h654321, 24'hFEDCBA, 24'h800001};
    logic [23:0] br[4] = '{24'h0000FF, 24'hFF0000, 24'h7FFFFF, 24'h000001};
    resync(32);
    txEnable = 1'b1;
    sampleValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int t = 0;
      sampleLeft = bl[i]; sampleRight = br[i];
      while (!sampleReady && t < 6000) begin
        @(negedge synthClk); t++;
      end
      @(negedge synthClk);
      if (t >= 6000) begin
        tests++; fails++;
        $display("FAIL b2b_accept%0d: sampleReady never rose, required 1", i);
      end
    end
    sampleValid = 1'b0;
    wait_q(9);
    tests++; if (underrunCount !== 8'd0) begin fails++; $display("FAIL b2b_count: got %0d required 0", underrunCount); end
    tests++; if (urCnt !== 0) begin fails++; $display("FAIL b2b_pulses: got %0d required 0", urCnt); end
    wait_q(10);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (getq(2 + 2 * i) !== {1'b0, bl[i], 8'h00}) begin
        fails++; $display("FAIL b2b_left%0d: got %h required %h", i, getq(2 + 2 * i), {1'b0, bl[i], 8'h00});
      end
      tests++;
      if (getq(3 + 2 * i) !== {1'b1, br[i], 8'h00}) begin
        fails++; $display("FAIL b2b_right%0d: got %h required %h", i, getq(3 + 2 * i), {1'b1, br[i], 8'h00});
      end
    end
  endtask

  task automatic test_underrun;
    int t = 0;
    resync(32);
    txEnable = 1'b1;
    // Stop one synthClk before the bclk fall that takes wclk 1->0.
    do begin
      @(negedge synthClk); #1; t++;
    end while (!(wclk && bclk && hc == 3 && bc == slotBits - 1) && t < 5000);
    @(negedge synthClk);
    sampleLeft = 24'hC0FFEE; sampleRight = 24'h0BADF0; sampleValid = 1'b1;
    @(negedge synthClk);
    sampleValid = 1'b0;
    tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL ur_pulse: got %b required 1", underrun); end
    tests++; if (sampleReady !== 1'b0) begin fails++; $display("FAIL ur_kept: got %b required 0", sampleReady); end
    wait_q(5);
    tests++; if (getq(2) !== {1'b0, 32'h0}) begin fails++; $display("FAIL ur_left_zero: got %h required %h", getq(2), {1'b0, 32'h0}); end
    tests++; if (getq(3) !== {1'b1, 32'h0}) begin fails++; $display("FAIL ur_right_zero: got %h required %h", getq(3), {1'b1, 32'h0}); end
    tests++; if (underrunCount !== 8'd1) begin fails++; $display("FAIL ur_count: got %0d required 1", underrunCount); end
    tests++; if (urCnt !== 1) begin fails++; $display("FAIL ur_pulses: got %0d required 1", urCnt); end
    wait_q(6);
    tests++; if (getq(4) !== {1'b0, 32'hC0FFEE00}) begin fails++; $display("FAIL ur_next_left: got %h required %h", getq(4), {1'b0, 32'hC0FFEE00}); end
    tests++; if (getq(5) !== {1'b1, 32'h0BADF000}) begin fails++; $display("FAIL ur_next_right: got %h required %h", getq(5), {1'b1, 32'h0BADF000}); end
  endtask

  task automatic test_truncation;
    resync(16);
    txEnable = 1'b1;
    send_pair(24'hFFF0F0, 24'h123456);
    wait_q(4);
    tests++; if (getq(2) !== {1'b0, 32'h0000FFF0}) begin fails++; $display("FAIL trunc_left: got %h required %h", getq(2), {1'b0, 32'h0000FFF0}); end
    tests++; if (getq(3) !== {1'b1, 32'h00001234}) begin fails++; $display("FAIL trunc_right: got %h required %h", getq(3), {1'b1, 32'h00001234}); end
  endtask

  task automatic test_restart;
    resync(32);
    txEnable = 1'b1;
    send_pair(24'hFFFFFF, 24'h000001);
    send_pair(24'h5A5A5A, 24'h0F0F0F);
    wait_q(2);
    repeat (16) @(negedge synthClk);
    tests++; if (sd !== 1'b1) begin fails++; $display("FAIL rst_pre_sd: got %b required 1", sd); end
    cuLoad = 1'b1; restart = 1'b1;
    @(negedge synthClk); #1;
    tests++; if (sd !== 1'b0) begin fails++; $display("FAIL rst_sd: got %b required 0", sd); end
    tests++; if (sampleReady !== 1'b0) begin fails++; $display("FAIL rst_hold_kept: got %b required 0", sampleReady); end
    @(negedge synthClk);
    cuLoad = 1'b0; restart = 1'b0;
    wait_q(4);
    tests++; if (getq(0) !== {1'b0, 32'h0}) begin fails++; $display("FAIL rst_idle0: got %h required %h", getq(0), {1'b0, 32'h0}); end
    tests++; if (getq(1) !== {1'b1, 32'h0}) begin fails++; $display("FAIL rst_idle1: got %h required %h", getq(1), {1'b1, 32'h0}); end
    tests++; if (getq(2) !== {1'b0, 32'h5A5A5A00}) begin fails++; $display("FAIL rst_left: got %h required %h", getq(2), {1'b0, 32'h5A5A5A00}); end
    tests++; if (getq(3) !== {1'b1, 32'h0F0F0F00}) begin fails++; $display("FAIL rst_right: got %h required %h", getq(3), {1'b1, 32'h0F0F0F00}); end
  endtask

  task automatic test_saturation;
    resync(4);
    txEnable = 1'b1;
    wait_q(508);
    tests++; if (underrunCount !== 8'd254) begin fails++; $display("FAIL sat_254: got %0d required 254", underrunCount); end
    wait_q(510);
    tests++; if (underrunCount !== 8'd255) begin fails++; $display("FAIL sat_255: got %0d required 255", underrunCount); end
    wait_q(604);
    tests++; if (underrunCount !== 8'd255) begin fails++; $display("FAIL sat_hold: got %0d required 255", underrunCount); end
    tests++; if (urCnt !== 302) begin fails++; $display("FAIL sat_pulses: got %0d required 302", urCnt); end
  endtask

  task automatic test_disable;
    resync(32);
    txEnable = 1'b1;
    send_pair(24'hABCDEF, 24'h123456);
    send_pair(24'h777777, 24'h888888);
    wait_q(2);
    repeat (16) @(negedge synthClk);
    txEnable = 1'b0;
    wait_q(6);
    tests++; if (getq(2) !== {1'b0, 32'hABCDEF00}) begin fails++; $display("FAIL dis_left: got %h required %h", getq(2), {1'b0, 32'hABCDEF00}); end
    tests++; if (getq(3) !== {1'b1, 32'h12345600}) begin fails++; $display("FAIL dis_right: got %h required %h", getq(3), {1'b1, 32'h12345600}); end
    tests++; if (getq(4) !== {1'b0, 32'h0}) begin fails++; $display("FAIL dis_idle_left: got %h required %h", getq(4), {1'b0, 32'h0}); end
    tests++; if (getq(5) !== {1'b1, 32'h0}) begin fails++; $display("FAIL dis_idle_right: got %h required %h", getq(5), {1'b1, 32'h0}); end
    tests++; if (sampleReady !== 1'b0) begin fails++; $display("FAIL dis_no_consume: got %b required 0", sampleReady); end
    tests++; if (urCnt !== 0) begin fails++; $display("FAIL dis_no_underrun: got %0d required 0", urCnt); end
    tests++; if (sd !== 1'b0) begin fails++; $display("FAIL dis_sd: got %b required 0", sd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_truncation();
    test_restart();
    test_saturation();
    test_disable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Downstream consumer of the I2S master clock unit's bclk/wclk. Accepts stereo sample pairs over a valid/ready handshake, buffers one pair, and shifts them MSB-first onto the serial data line in standard I2S format: one-bit delay after each wclk transition, left slot while wclk=0. All logic runs in the synthClk domain. bclk and wclk are treated as synchronous level inputs, and their edges are detected internally.

## Interface
- SAMPLE_WIDTH, 24, bits per channel sample (8..32)
- synthClk  in  1  system clock, same clock as the clock unit
- synthReset  in  1  asynchronous, active-high reset
- bclk  in  1  registered bit clock from clock unit
- wclk  in  1  registered word clock from clock unit
- restart  in  1  synchronous resync; tied to the clock unit's loadEn
- txEnable  in  1  transmit enable, sampled at frame boundaries
- sampleValid  in  1  upstream pair valid
- sampleLeft  in  SAMPLE_WIDTH  left sample
- sampleRight  in  SAMPLE_WIDTH  right sample
- sampleReady  out  1  holding register empty; equals !holdValid
- sd  out  1  serial data, registered
- underrun  out  1  one-cycle pulse: frame started with an empty holding register
- underrunCount  out  8  saturating underrun count

## Operation
- Event detection:
  - bclkFall = bclkPrev & !bclk. bclkPrev updates every cycle.
  - wclkLast captures wclk only on bclkFall cycles.
  - On a bclkFall cycle, toggle = (wclk != wclkLast). A wclk change at a bclk rising edge is therefore seen at the next fall.
- Serialization on every bclkFall:
  - sd <= shreg[MSB].
  - shreg <= toggle ? newWord : shreg<<1, zero fill.
  - The edge where wclk toggles emits the last bit of the old slot, giving the I2S one-bit delay.
  - A slot longer than SAMPLE_WIDTH pads with zeros. A shorter slot truncates LSBs.
- Holding buffer:
  - One entry: holdL, holdR, holdValid.
  - Accept when sampleValid && sampleReady.
  - Accept and consume never coincide, because accept requires the buffer empty and consume requires it full.
- FSM states IDLE, LEFT, RIGHT, with transitions only on bclkFall && toggle:
  - IDLE: newWord=0. If txEnable && wclk==0, go to LEFT.
  - IDLE→LEFT and RIGHT→LEFT, frame start:
    - If holdValid: newWord=holdL, rightWord<=holdR, holdValid<=0.
    - Else: newWord=0, rightWord<=0, underrun pulse, underrunCount+1 saturating at 255.
    - A same-cycle upstream accept into the empty buffer is kept for the next frame.
  - LEFT→RIGHT: newWord=rightWord.
  - RIGHT on toggle with txEnable=0: newWord=0, go to IDLE.
  - A wclk toggle to 1 seen in IDLE is ignored.
- restart, highest priority below reset, takes effect the next cycle:
  - state IDLE, shreg 0, sd 0, bclkPrev 0, wclkLast 0, underrunCount 0.
  - holdValid and hold data are preserved.
- Reset values: sd 0, underrun 0, underrunCount 0, holdValid 0 (so sampleReady=1), state IDLE, shreg 0, rightWord 0, bclkPrev 0, wclkLast 0.

## Timing
- sd updates exactly one synthClk after the cycle in which bclk is observed low following high.
- Requirement: bclk half-period ≥ 2 synthClk, i.e. mclkDivider·bclkDivider ≥ 2. This guarantees sd is stable at the bclk rising edge.
- Frame start to first MSB: MSB appears on sd one synthClk after the second bclkFall following the wclk 1→0 toggle. The toggle-edge bclkFall emits the previous slot's bit; the next bclkFall emits the MSB.
- The underrun pulse is asserted in the cycle after the frame-start bclkFall.
- sampleReady rises the cycle after consumption. sampleReady is combinational from holdValid.

## Structure
- Package i2s_pkg holds:
  - the state enum (IDLE, LEFT, RIGHT)
  - the SAMPLE_WIDTH default
  - the underrunCount width constant
- One sub-module, i2s_clock_edge_detect:
  - registers bclkPrev and wclkLast
  - outputs bclkFall and toggle
  - clears on restart
  - is reusable by a future i2s receive deserializer.
- Shift register, holding buffer and FSM are in the top module.

## Test plan
Setup for all scenarios: clock unit dividers mclk=2, bclk=2, wclk=64, giving a 32-bit slot.
- Basic frame: pair L=0xA5A5A5, R=0x3C3C3C with txEnable=1 → sd, sampled at bclk rises, shows left bits 23..0 then 8 zeros starting one bclk after wclk falls, and the right channel likewise after wclk rises. sampleReady drops for one frame.
- Back-to-back: 4 pairs streamed with sampleValid held high → no underrun, and consecutive frames are gapless.
- Underrun: no sample at frame start → sd all zeros for the frame, one underrun pulse, underrunCount=1. A sample arriving in the same cycle is played next frame.
- Truncation: wclk=32 (16-bit slot), L=0xFFF0F0 → sd emits sample bits 23..8 = 0xFFF0.
- Restart mid-LEFT → sd=0 next cycle, state IDLE, buffered pair retained and played in the first frame after the next wclk fall.
- Disable and saturation:
  - txEnable dropped mid-frame → the right slot completes, then sd stays 0 with no further consumption.
  - 300 consecutive underruns → underrunCount=255.
